ctrl_sim_multi: RTL and testbench

Parametrised successor to the single-port controller model used in the NES bench; one instance serves NUM_PORTS controller ports.
Each port is a latched parallel-in/serial-out shift register of configurable report width (8 = NES pad, 16 = extended pad).
Button state comes either from an external bus or from a per-port, frame-synchronised script table loaded over a write port.
The block sits on clk_cpu beside the nes core: ctrl_strobe/ctrl_out in, ctrl_data out, vblank in for script timing.

---
 rtl/ctrl_sim_multi_pkg.sv | 28 ++
 rtl/ctrl_sim_multi_if.sv | 30 +++
 rtl/ctrl_sim_multi_shift_port.sv | 37 +++
 rtl/ctrl_sim_multi.sv | 138 +++++++++++++
 tb/tb_ctrl_sim_multi.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_sim_multi_pkg.sv
// Shared types and constants for the multi-port controller model.
// Script entries use fixed maximum widths so one struct serves every instance.
package ctrl_sim_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int FRAME_MAX_W = 32;
    localparam int BITS_MAX    = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } seq_state_t;

    typedef struct packed {
        logic [FRAME_MAX_W-1:0] frame;
        logic [BITS_MAX-1:0]    btns;
    } script_entry_t;

endpackage

// File: rtl/ctrl_sim_multi_if.sv
// CPU-side controller bus plus the script table write port.
interface ctrl_sim_multi_if #(
    parameter int NUM_PORTS    = 2,
    parameter int BITS         = 8,
    parameter int SCRIPT_DEPTH = 16,
    parameter int FRAME_W      = 16
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = (SCRIPT_DEPTH > 1) ? $clog2(SCRIPT_DEPTH) : 1;

    logic [NUM_PORTS-1:0] strobe;
    logic [NUM_PORTS-1:0] rd;
    logic [NUM_PORTS-1:0] data;
    logic                 scr_wr;
    logic [PW-1:0]        scr_port;
    logic [AW-1:0]        scr_idx;
    logic [FRAME_W-1:0]   scr_frame;
    logic [BITS-1:0]      scr_btns;

    modport master (
        output strobe, rd, scr_wr, scr_port, scr_idx, scr_frame, scr_btns,
        input  data
    );

    modport slave (
        input  strobe, rd, scr_wr, scr_port, scr_idx, scr_frame, scr_btns,
        output data
    );

endinterface

// File: rtl/ctrl_sim_multi_shift_port.sv
// One controller port: latched parallel-in/serial-out report register.
// Shifts on the falling edge of rd so the CPU sees the old bit during its access.
module ctrl_shift_port #(
    parameter int   BITS = 8,
    parameter logic FILL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            strobe,
    input  logic            rd,
    input  logic [BITS-1:0] src,
    output logic            data
);

    logic            rd_q;
    logic [BITS-1:0] shift;
    logic [BITS:0]   shift_ext;

    // Prepending FILL and dropping bit 0 also works for a 1-bit report.
    assign shift_ext = {FILL, shift};
    assign data      = shift[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= 1'b0;
            shift <= '0;
        end else begin
            rd_q <= rd;
            if (strobe) begin
                shift <= src;
            end else if (rd_q && !rd) begin
                shift <= shift_ext[BITS:1];
            end
        end
    end

endmodule

// File: rtl/ctrl_sim_multi.sv
// Multi-port controller model: frame counter, per-port script tables and
// sequencers feeding one shift port each.
module ctrl_sim_multi
    import ctrl_sim_pkg::*;
#(
    parameter int   NUM_PORTS    = 2,
    parameter int   BITS         = 8,
    parameter logic FILL         = 1'b1,
    parameter int   SCRIPT_DEPTH = 16,
    parameter int   FRAME_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ctrl_sim_multi_if.slave           bus,
    input  logic [NUM_PORTS*BITS-1:0] btns_ext,
    input  logic                      vblank,
    input  logic                      script_en,
    output logic [FRAME_W-1:0]        frame_cnt,
    output logic [NUM_PORTS-1:0]      script_done
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = (SCRIPT_DEPTH > 1) ? $clog2(SCRIPT_DEPTH) : 1;
    localparam int LW = AW + 1;

    logic                 vblank_q;
    logic [NUM_PORTS-1:0] data_vec;
    logic [NUM_PORTS-1:0] done_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vblank_q  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vblank_q <= vblank;
            if (vblank && !vblank_q && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        script_entry_t   mem [SCRIPT_DEPTH];
        script_entry_t   cur;
        seq_state_t      state, state_nxt;
        logic [LW-1:0]   len, ptr, ptr_nxt;
        logic [BITS-1:0] btns_q, btns_nxt, src;
        logic            wr_sel, hit, unused_hi;

        assign wr_sel    = bus.scr_wr && !script_en && (bus.scr_port == PW'(p));
        assign cur       = mem[ptr[AW-1:0]];
        assign hit       = cur.frame <= FRAME_MAX_W'(frame_cnt);
        assign unused_hi = ^cur.btns;

        always_ff @(posedge clk) begin
            if (wr_sel) begin
                mem[bus.scr_idx] <= '{frame: FRAME_MAX_W'(bus.scr_frame),
                                      btns:  BITS_MAX'(bus.scr_btns)};
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                len <= '0;
            end else if (wr_sel) begin
                len <= {1'b0, bus.scr_idx} + LW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state  <= SEQ_IDLE;
                ptr    <= '0;
                btns_q <= '0;
            end else begin
                state  <= state_nxt;
                ptr    <= ptr_nxt;
                btns_q <= btns_nxt;
            end
        end

        // Past-due entries are taken one per clock, so a restart catches up gradually.
        always_comb begin
            state_nxt = state;
            ptr_nxt   = ptr;
            btns_nxt  = btns_q;
            case (state)
                SEQ_IDLE: begin
                    ptr_nxt = '0;
                    if (script_en) begin
                        state_nxt = (len == '0) ? SEQ_DONE : SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (!script_en) begin
                        state_nxt = SEQ_IDLE;
                        ptr_nxt   = '0;
                    end else if (hit) begin
                        btns_nxt = BITS'(cur.btns);
                        ptr_nxt  = ptr + LW'(1);
                        if (ptr + LW'(1) == len) begin
                            state_nxt = SEQ_DONE;
                        end
                    end
                end
                SEQ_DONE: begin
                    if (!script_en) begin
                        state_nxt = SEQ_IDLE;
                        ptr_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = SEQ_IDLE;
                    ptr_nxt   = '0;
                end
            endcase
        end

        assign src         = script_en ? btns_q : btns_ext[p*BITS +: BITS];
        assign done_vec[p] = (state == SEQ_DONE);

        ctrl_shift_port #(
            .BITS (BITS),
            .FILL (FILL)
        ) u_shift (
            .clk    (clk),
            .rst_n  (rst_n),
            .strobe (bus.strobe[p]),
            .rd     (bus.rd[p]),
            .src    (src),
            .data   (data_vec[p])
        );
    end

    assign bus.data    = data_vec;
    assign script_done = done_vec;

endmodule

// File: tb/tb_ctrl_sim_multi.sv
// Bench for ctrl_sim_multi: an 8-bit and a 16-bit instance, expected report
// bits queued when a report is latched and popped as each read returns.
module tb_ctrl_sim_multi;

    localparam logic FILL = 1'b1;

    logic        clk;
    logic        rst_n;
    logic [15:0] btns8;
    logic [31:0] btns16;
    logic        vblank8;
    logic        script_en8;
    logic        vblank16;
    logic        script_en16;
    logic [15:0] frame_cnt8;
    logic [15:0] frame_cnt16;
    logic [1:0]  done8;
    logic [1:0]  done16;

    int          checks;
    int          errors;
    logic        exp_q [$];
    logic [15:0] exp_frame;
    int          ent_frame [2];
    logic [7:0]  ent_btns [2];

    ctrl_sim_multi_if #(.NUM_PORTS(2), .BITS(8),  .SCRIPT_DEPTH(16), .FRAME_W(16)) bus8 ();
    ctrl_sim_multi_if #(.NUM_PORTS(2), .BITS(16), .SCRIPT_DEPTH(16), .FRAME_W(16)) bus16 ();

    ctrl_sim_multi #(
        .NUM_PORTS(2), .BITS(8), .FILL(FILL), .SCRIPT_DEPTH(16), .FRAME_W(16)
    ) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus8),
        .btns_ext    (btns8),
        .vblank      (vblank8),
        .script_en   (script_en8),
        .frame_cnt   (frame_cnt8),
        .script_done (done8)
    );

    ctrl_sim_multi #(
        .NUM_PORTS(2), .BITS(16), .FILL(FILL), .SCRIPT_DEPTH(16), .FRAME_W(16)
    ) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus16),
        .btns_ext    (btns16),
        .vblank      (vblank16),
        .script_en   (script_en16),
        .frame_cnt   (frame_cnt16),
        .script_done (done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_report(input int frame);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 2; i++) begin
            if (ent_frame[i] <= frame) r = ent_btns[i];
        end
        return r;
    endfunction

    task automatic strobe_latch(input int which, input int p);
        @(negedge clk);
        if (which == 0) bus8.strobe[p] = 1'b1; else bus16.strobe[p] = 1'b1;
        @(negedge clk);
        if (which == 0) bus8.strobe[p] = 1'b0; else bus16.strobe[p] = 1'b0;
    endtask

    task automatic rd_pulse(input int which, input int p, output logic bit_o);
        @(negedge clk);
        if (which == 0) bus8.rd[p] = 1'b1; else bus16.rd[p] = 1'b1;
        @(negedge clk);
        bit_o = (which == 0) ? bus8.data[p] : bus16.data[p];
        if (which == 0) bus8.rd[p] = 1'b0; else bus16.rd[p] = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_report(input logic [15:0] val, input int width, input int extra);
        for (int i = 0; i < width + extra; i++) begin
            exp_q.push_back((i < width) ? val[i] : FILL);
        end
    endtask

    task automatic vblank_pulse();
        @(negedge clk);
        vblank8 = 1'b1;
        @(negedge clk);
        vblank8 = 1'b0;
        exp_frame = exp_frame + 16'd1;
        @(negedge clk);
    endtask

    task automatic scr_write(input int p, input int idx, input int frame, input logic [7:0] b);
        @(negedge clk);
        bus8.scr_wr    = 1'b1;
        bus8.scr_port  = p[0];
        bus8.scr_idx   = idx[3:0];
        bus8.scr_frame = frame[15:0];
        bus8.scr_btns  = b;
        @(negedge clk);
        bus8.scr_wr    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_frame = 16'd0;
        @(negedge clk);
        checks++;
        if (bus8.data !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_data8: got %b expected 00", bus8.data);
        end
        checks++;
        if (bus16.data !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_data16: got %b expected 00", bus16.data);
        end
        checks++;
        if (frame_cnt8 !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_frame: got %0d expected 0", frame_cnt8);
        end
        checks++;
        if (done8 !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_done: got %b expected 00", done8);
        end
    endtask

    task automatic test_read_sequence();
        logic got, exp;
        btns8 = 16'h5A09;
        strobe_latch(0, 0);
        push_report(16'h0009, 8, 2);
        for (int i = 0; i < 10; i++) begin
            rd_pulse(0, 0, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("[TB] FAIL read8_p0[%0d]: got %b expected %b", i, got, exp);
            end
        end
        strobe_latch(0, 1);
        push_report(16'h005A, 8, 1);
        for (int i = 0; i < 9; i++) begin
            rd_pulse(0, 1, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("[TB] FAIL read8_p1[%0d]: got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_strobe_held();
        logic exp;
        @(negedge clk);
        btns8[7:0] = 8'h01;
        bus8.strobe[0] = 1'b1;
        exp_q.push_back(1'b1);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (bus8.data[0] !== exp) begin
            errors++; $display("[TB] FAIL held_follow1: got %b expected %b", bus8.data[0], exp);
        end
        bus8.rd[0] = 1'b1;
        @(negedge clk);
        bus8.rd[0] = 1'b0;
        exp_q.push_back(1'b1);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (bus8.data[0] !== exp) begin
            errors++; $display("[TB] FAIL held_noshift: got %b expected %b", bus8.data[0], exp);
        end
        btns8[7:0] = 8'h00;
        bus8.rd[0] = 1'b1;
        exp_q.push_back(1'b0);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (bus8.data[0] !== exp) begin
            errors++; $display("[TB] FAIL held_follow0: got %b expected %b", bus8.data[0], exp);
        end
        btns8[7:0] = 8'h01;
        bus8.rd[0] = 1'b0;
        exp_q.push_back(1'b1);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (bus8.data[0] !== exp) begin
            errors++; $display("[TB] FAIL held_rdfall: got %b expected %b", bus8.data[0], exp);
        end
        bus8.strobe[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wide();
        logic got, exp;
        btns16[15:0] = 16'hA5C3;
        strobe_latch(1, 0);
        push_report(16'hA5C3, 16, 2);
        for (int i = 0; i < 18; i++) begin
            rd_pulse(1, 0, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("[TB] FAIL read16[%0d]: got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_script();
        logic got, exp;
        ent_frame[0] = 2; ent_btns[0] = 8'h08;
        ent_frame[1] = 5; ent_btns[1] = 8'h01;
        scr_write(1, 0, ent_frame[0], ent_btns[0]);
        scr_write(1, 1, ent_frame[1], ent_btns[1]);
        @(negedge clk);
        script_en8 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done8 !== 2'b01) begin
            errors++; $display("[TB] FAIL script_done_start: got %b expected 01", done8);
        end
        for (int f = 0; f <= 5; f++) begin
            if (f > 0) vblank_pulse();
            checks++;
            if (frame_cnt8 !== exp_frame) begin
                errors++; $display("[TB] FAIL frame_cnt@%0d: got %0d expected %0d", f, frame_cnt8, exp_frame);
            end
            checks++;
            if (done8[1] !== (f >= 5)) begin
                errors++; $display("[TB] FAIL done1@%0d: got %b expected %b", f, done8[1], (f >= 5));
            end
            strobe_latch(0, 1);
            push_report({8'h00, model_report(f)}, 8, 0);
            for (int i = 0; i < 8; i++) begin
                rd_pulse(0, 1, got);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++; $display("[TB] FAIL script@%0d[%0d]: got %b expected %b", f, i, got, exp);
                end
            end
        end
    endtask

    task automatic test_restart();
        logic got, exp;
        rst_n = 1'b0;
        script_en8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_frame = 16'd0;
        scr_write(1, 0, ent_frame[0], ent_btns[0]);
        scr_write(1, 1, ent_frame[1], ent_btns[1]);
        repeat (3) vblank_pulse();
        checks++;
        if (frame_cnt8 !== 16'd3) begin
            errors++; $display("[TB] FAIL restart_frame: got %0d expected 3", frame_cnt8);
        end
        script_en8 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done8 !== 2'b01) begin
            errors++; $display("[TB] FAIL restart_run_done: got %b expected 01", done8);
        end
        script_en8 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done8 !== 2'b00) begin
            errors++; $display("[TB] FAIL restart_abort_done: got %b expected 00", done8);
        end
        script_en8 = 1'b1;
        scr_write(1, 1, 0, 8'hFF);
        for (int f = 3; f <= 5; f++) begin
            if (f > 3) vblank_pulse();
            repeat (2) @(negedge clk);
            strobe_latch(0, 1);
            push_report({8'h00, model_report(f)}, 8, 0);
            for (int i = 0; i < 8; i++) begin
                rd_pulse(0, 1, got);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++; $display("[TB] FAIL restart@%0d[%0d]: got %b expected %b", f, i, got, exp);
                end
            end
        end
        checks++;
        if (done8 !== 2'b11) begin
            errors++; $display("[TB] FAIL restart_end_done: got %b expected 11", done8);
        end
    endtask

    task automatic test_reset_mid();
        logic got, exp;
        @(negedge clk);
        script_en8 = 1'b0;
        btns8[7:0] = 8'h6D;
        strobe_latch(0, 0);
        push_report(16'h006D, 8, 0);
        for (int i = 0; i < 3; i++) begin
            rd_pulse(0, 0, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("[TB] FAIL midshift[%0d]: got %b expected %b", i, got, exp);
            end
        end
        exp_q.delete();
        script_en8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus8.data !== 2'b00) begin
            errors++; $display("[TB] FAIL midreset_data: got %b expected 00", bus8.data);
        end
        checks++;
        if (frame_cnt8 !== 16'd0) begin
            errors++; $display("[TB] FAIL midreset_frame: got %0d expected 0", frame_cnt8);
        end
        checks++;
        if (done8 !== 2'b00) begin
            errors++; $display("[TB] FAIL midreset_done: got %b expected 00", done8);
        end
        script_en8 = 1'b0;
        rst_n = 1'b1;
        exp_frame = 16'd0;
        strobe_latch(0, 0);
        push_report(16'h006D, 8, 1);
        for (int i = 0; i < 9; i++) begin
            rd_pulse(0, 0, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("[TB] FAIL reload[%0d]: got %b expected %b", i, got, exp);
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        btns8          = '0;
        btns16         = '0;
        vblank8        = 1'b0;
        vblank16       = 1'b0;
        script_en8     = 1'b0;
        script_en16    = 1'b0;
        exp_frame      = 16'd0;
        bus8.strobe    = '0;
        bus8.rd        = '0;
        bus8.scr_wr    = 1'b0;
        bus8.scr_port  = '0;
        bus8.scr_idx   = '0;
        bus8.scr_frame = '0;
        bus8.scr_btns  = '0;
        bus16.strobe   = '0;
        bus16.rd       = '0;
        bus16.scr_wr   = 1'b0;
        bus16.scr_port = '0;
        bus16.scr_idx  = '0;
        bus16.scr_frame = '0;
        bus16.scr_btns = '0;

        test_reset();
        test_read_sequence();
        test_strobe_held();
        test_wide();
        test_script();
        test_restart();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
